// File: rtl/bram_arb_pkg.sv
// Shared types and default widths for the two-client BRAM port arbiter.
package bram_arb_pkg;
    localparam int DEF_DWIDTH = 8;
    localparam int DEF_AWIDTH = 8;

    typedef logic client_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;
endpackage

// File: rtl/bram_port_arbiter_if.sv
// Client request/response and BRAM port bundle between two clients, the arbiter and an external BRAM.
interface bram_port_arbiter_if import bram_arb_pkg::*; #(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int AWIDTH = DEF_AWIDTH
);
    logic              c0_valid, c1_valid;
    logic              c0_we, c1_we;
    logic [AWIDTH-1:0] c0_addr, c1_addr;
    logic [DWIDTH-1:0] c0_wdata, c1_wdata;
    logic              c0_ready, c1_ready;
    logic              c0_rvalid, c1_rvalid;
    logic [DWIDTH-1:0] c0_rdata, c1_rdata;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_wr_addr;
    logic [DWIDTH-1:0] mem_din;
    logic [AWIDTH-1:0] mem_rd_addr;
    logic [DWIDTH-1:0] mem_dout;

    // Arbiter side.
    modport slave (
        input  c0_valid, c1_valid, c0_we, c1_we, c0_addr, c1_addr,
               c0_wdata, c1_wdata, mem_dout,
        output c0_ready, c1_ready, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
               mem_we, mem_wr_addr, mem_din, mem_rd_addr
    );

    // Clients plus BRAM side.
    modport master (
        output c0_valid, c1_valid, c0_we, c1_we, c0_addr, c1_addr,
               c0_wdata, c1_wdata, mem_dout,
        input  c0_ready, c1_ready, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
               mem_we, mem_wr_addr, mem_din, mem_rd_addr
    );
endinterface

// File: rtl/bram_arb_pick.sv
// Two-requester round-robin picker: grant is combinational from the requests, zero added latency.
// Pointer names the favoured client on contention and moves to the loser afterwards.
module bram_arb_pick import bram_arb_pkg::*; (
    input  logic    clock,
    input  logic    resetn,
    input  logic    i_req0,
    input  logic    i_req1,
    output logic    o_gnt_vld,
    output client_t o_gnt_id
);
    client_t r_ptr;
    client_t w_ptr_nxt;

    always_comb begin
        o_gnt_vld = 1'b0;
        o_gnt_id  = 1'b0;
        w_ptr_nxt = r_ptr;
        if (resetn) begin
            if (i_req0 && i_req1) begin
                o_gnt_vld = 1'b1;
                o_gnt_id  = r_ptr;
                w_ptr_nxt = ~r_ptr;
            end else if (i_req0) begin
                o_gnt_vld = 1'b1;
                o_gnt_id  = 1'b0;
            end else if (i_req1) begin
                o_gnt_vld = 1'b1;
                o_gnt_id  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) r_ptr <= 1'b0;
        else         r_ptr <= w_ptr_nxt;
    end
endmodule

// File: rtl/bram_port_arbiter.sv
// Arbitrates two clients onto the write and read ports of an external simple-dual-port BRAM.
// Grants are same-cycle; read data returns one cycle after grant. Losers hold valid until ready.
module bram_port_arbiter import bram_arb_pkg::*; #(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int AWIDTH = DEF_AWIDTH
) (
    input  logic clock,
    input  logic resetn,
    bram_port_arbiter_if.slave bus
);
    op_e               w_op0, w_op1;
    logic              w_wreq0, w_wreq1, w_rreq0, w_rreq1;
    logic              w_wgnt_vld, w_rgnt_vld;
    client_t           w_wgnt_id, w_rgnt_id;
    logic [AWIDTH-1:0] w_wr_addr, w_rd_addr;
    logic [DWIDTH-1:0] w_din;
    logic              w_rvalid0, w_rvalid1;
    logic              r_rsp_vld;
    client_t           r_rsp_id;

    assign w_op0   = op_e'(bus.c0_we);
    assign w_op1   = op_e'(bus.c1_we);
    assign w_wreq0 = bus.c0_valid && (w_op0 == OP_WRITE);
    assign w_wreq1 = bus.c1_valid && (w_op1 == OP_WRITE);
    assign w_rreq0 = bus.c0_valid && (w_op0 == OP_READ);
    assign w_rreq1 = bus.c1_valid && (w_op1 == OP_READ);

    bram_arb_pick u_wr_pick (
        .clock     (clock),
        .resetn    (resetn),
        .i_req0    (w_wreq0),
        .i_req1    (w_wreq1),
        .o_gnt_vld (w_wgnt_vld),
        .o_gnt_id  (w_wgnt_id)
    );

    bram_arb_pick u_rd_pick (
        .clock     (clock),
        .resetn    (resetn),
        .i_req0    (w_rreq0),
        .i_req1    (w_rreq1),
        .o_gnt_vld (w_rgnt_vld),
        .o_gnt_id  (w_rgnt_id)
    );

    always_comb begin
        w_wr_addr = '0;
        w_din     = '0;
        w_rd_addr = '0;
        if (w_wgnt_vld) begin
            w_wr_addr = w_wgnt_id ? bus.c1_addr  : bus.c0_addr;
            w_din     = w_wgnt_id ? bus.c1_wdata : bus.c0_wdata;
        end
        if (w_rgnt_vld) begin
            w_rd_addr = w_rgnt_id ? bus.c1_addr : bus.c0_addr;
        end
    end

    assign bus.mem_we      = w_wgnt_vld;
    assign bus.mem_wr_addr = w_wr_addr;
    assign bus.mem_din     = w_din;
    assign bus.mem_rd_addr = w_rd_addr;

    assign bus.c0_ready = (w_wgnt_vld && (w_wgnt_id == 1'b0)) || (w_rgnt_vld && (w_rgnt_id == 1'b0));
    assign bus.c1_ready = (w_wgnt_vld && (w_wgnt_id == 1'b1)) || (w_rgnt_vld && (w_rgnt_id == 1'b1));

    // Tracks which client owns the BRAM data arriving next cycle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_rsp_vld <= 1'b0;
            r_rsp_id  <= 1'b0;
        end else begin
            r_rsp_vld <= w_rgnt_vld;
            r_rsp_id  <= w_rgnt_id;
        end
    end

    // Masking with resetn drops a response whose read was granted just before reset.
    assign w_rvalid0 = resetn && r_rsp_vld && (r_rsp_id == 1'b0);
    assign w_rvalid1 = resetn && r_rsp_vld && (r_rsp_id == 1'b1);

    assign bus.c0_rvalid = w_rvalid0;
    assign bus.c1_rvalid = w_rvalid1;
    assign bus.c0_rdata  = w_rvalid0 ? bus.mem_dout : '0;
    assign bus.c1_rdata  = w_rvalid1 ? bus.mem_dout : '0;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with an emulated BRAM and a per-cycle reference model.
module tb_bram_port_arbiter;
    logic clock;
    logic resetn;
    int   total = 0;
    int   bad   = 0;

    bram_port_arbiter_if bus_if ();

    bram_port_arbiter dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus_if)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want finish before it");
        $fatal(1, "watchdog");
    end

    // External BRAM: registered read, read-before-write on a same-address collision.
    logic [7:0] bram [256];
    logic [7:0] shadow [256];

    initial begin
        for (int i = 0; i < 256; i++) begin
            bram[i]   = 8'(i) ^ 8'h5A;
            shadow[i] = 8'(i) ^ 8'h5A;
        end
        bus_if.mem_dout = 8'h00;
    end

    always @(posedge clock) begin
        bus_if.mem_dout <= bram[bus_if.mem_rd_addr];
        if (bus_if.mem_we) bram[bus_if.mem_wr_addr] <= bus_if.mem_din;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: favoured client per port (0 = write port, 1 = read port).
    int         pri [2];
    logic       pend_vld;
    int         pend_id;
    logic [7:0] pend_dat;

    initial begin
        pri[0] = 0;
        pri[1] = 0;
        pend_vld = 1'b0;
        pend_id  = 0;
        pend_dat = 8'h00;
    end

    function automatic int pick(input int p, input logic [1:0] req);
        int w;
        if (req == 2'b11) begin
            w = pri[p];
            pri[p] = 1 - w;
            return w;
        end
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    always @(negedge clock) begin
        logic [1:0] wreq, rreq;
        logic [7:0] addr [2];
        logic [7:0] wdat [2];
        int wg, rg;
        logic [7:0] e_wa, e_din, e_ra;
        addr[0] = bus_if.c0_addr;  addr[1] = bus_if.c1_addr;
        wdat[0] = bus_if.c0_wdata; wdat[1] = bus_if.c1_wdata;
        if (!resetn) begin
            chk("m_rst_c0_ready", bus_if.c0_ready, 0);
            chk("m_rst_c1_ready", bus_if.c1_ready, 0);
            chk("m_rst_c0_rvalid", bus_if.c0_rvalid, 0);
            chk("m_rst_c1_rvalid", bus_if.c1_rvalid, 0);
            chk("m_rst_mem_we", bus_if.mem_we, 0);
            chk("m_rst_wr_addr", bus_if.mem_wr_addr, 0);
            chk("m_rst_din", bus_if.mem_din, 0);
            chk("m_rst_rd_addr", bus_if.mem_rd_addr, 0);
            chk("m_rst_c0_rdata", bus_if.c0_rdata, 0);
            chk("m_rst_c1_rdata", bus_if.c1_rdata, 0);
            pri[0] = 0;
            pri[1] = 0;
            pend_vld = 1'b0;
        end else begin
            wreq = {bus_if.c1_valid & bus_if.c1_we,  bus_if.c0_valid & bus_if.c0_we};
            rreq = {bus_if.c1_valid & ~bus_if.c1_we, bus_if.c0_valid & ~bus_if.c0_we};
            wg = pick(0, wreq);
            rg = pick(1, rreq);
            e_wa  = (wg >= 0) ? addr[wg] : 8'h00;
            e_din = (wg >= 0) ? wdat[wg] : 8'h00;
            e_ra  = (rg >= 0) ? addr[rg] : 8'h00;
            chk("m_c0_ready", bus_if.c0_ready, 32'((wg == 0) || (rg == 0)));
            chk("m_c1_ready", bus_if.c1_ready, 32'((wg == 1) || (rg == 1)));
            chk("m_mem_we", bus_if.mem_we, 32'(wg >= 0));
            chk("m_wr_addr", bus_if.mem_wr_addr, e_wa);
            chk("m_din", bus_if.mem_din, e_din);
            chk("m_rd_addr", bus_if.mem_rd_addr, e_ra);
            chk("m_c0_rvalid", bus_if.c0_rvalid, 32'(pend_vld && pend_id == 0));
            chk("m_c1_rvalid", bus_if.c1_rvalid, 32'(pend_vld && pend_id == 1));
            chk("m_c0_rdata", bus_if.c0_rdata, (pend_vld && pend_id == 0) ? pend_dat : 8'h00);
            chk("m_c1_rdata", bus_if.c1_rdata, (pend_vld && pend_id == 1) ? pend_dat : 8'h00);
            pend_vld = (rg >= 0);
            pend_id  = rg;
            pend_dat = (rg >= 0) ? shadow[addr[rg]] : 8'h00;
            if (wg >= 0) shadow[addr[wg]] = wdat[wg];
        end
    end

    task automatic drv(input logic v0, input logic we0, input logic [7:0] a0, input logic [7:0] d0,
                       input logic v1, input logic we1, input logic [7:0] a1, input logic [7:0] d1);
        bus_if.c0_valid = v0; bus_if.c0_we = we0; bus_if.c0_addr = a0; bus_if.c0_wdata = d0;
        bus_if.c1_valid = v1; bus_if.c1_we = we1; bus_if.c1_addr = a1; bus_if.c1_wdata = d1;
    endtask

    task automatic nxt;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        drv(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        nxt();
        // Active requests during reset must be ignored.
        drv(1, 1, 8'h10, 8'hA5, 1, 0, 8'h10, 8'h00);
        nxt();
        @(negedge clock);
        chk("rst_c0_ready", bus_if.c0_ready, 0);
        chk("rst_mem_we", bus_if.mem_we, 0);
        chk("rst_rd_addr", bus_if.mem_rd_addr, 0);

        // Single write then read-back.
        nxt();
        resetn = 1'b1;
        drv(1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00);
        @(negedge clock);
        chk("wr_mem_we", bus_if.mem_we, 1);
        chk("wr_addr", bus_if.mem_wr_addr, 8'h10);
        chk("wr_din", bus_if.mem_din, 8'hA5);
        chk("wr_c0_ready", bus_if.c0_ready, 1);
        nxt();
        drv(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        @(negedge clock);
        chk("rd_c0_ready", bus_if.c0_ready, 1);
        chk("rd_addr", bus_if.mem_rd_addr, 8'h10);
        chk("rd_c0_rvalid_early", bus_if.c0_rvalid, 0);
        nxt();
        idle();
        @(negedge clock);
        chk("rd_c0_rvalid", bus_if.c0_rvalid, 1);
        chk("rd_c0_rdata", bus_if.c0_rdata, 8'hA5);
        chk("rd_c1_rvalid", bus_if.c1_rvalid, 0);

        // Sustained write contention alternates c0,c1,c0,c1.
        for (int i = 0; i < 4; i++) begin
            nxt();
            drv(1, 1, 8'h30, 8'h11, 1, 1, 8'h31, 8'h22);
            @(negedge clock);
            chk("wc_c0_ready", bus_if.c0_ready, 32'(i % 2 == 0));
            chk("wc_c1_ready", bus_if.c1_ready, 32'(i % 2 == 1));
            chk("wc_wr_addr", bus_if.mem_wr_addr, (i % 2 == 0) ? 8'h30 : 8'h31);
        end

        // Same-address write and read in one cycle returns the old data.
        nxt();
        drv(1, 1, 8'h20, 8'h3C, 1, 0, 8'h20, 8'h00);
        @(negedge clock);
        chk("rw_c0_ready", bus_if.c0_ready, 1);
        chk("rw_c1_ready", bus_if.c1_ready, 1);
        nxt();
        drv(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00);
        @(negedge clock);
        chk("rw_old_rvalid", bus_if.c1_rvalid, 1);
        chk("rw_old_rdata", bus_if.c1_rdata, 8'h7A);
        nxt();
        idle();
        @(negedge clock);
        chk("rw_new_rdata", bus_if.c1_rdata, 8'h3C);

        // Continuous read contention: responses alternate with each client's own data.
        for (int i = 0; i < 5; i++) begin
            nxt();
            if (i < 4) drv(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
            else       idle();
            @(negedge clock);
            if (i > 0) begin
                chk("rc_c0_rvalid", bus_if.c0_rvalid, 32'((i - 1) % 2 == 0));
                chk("rc_c1_rvalid", bus_if.c1_rvalid, 32'((i - 1) % 2 == 1));
                chk("rc_c0_rdata", bus_if.c0_rdata, ((i - 1) % 2 == 0) ? 8'h5B : 8'h00);
                chk("rc_c1_rdata", bus_if.c1_rdata, ((i - 1) % 2 == 1) ? 8'h58 : 8'h00);
            end
        end

        // Leave the write pointer on c1, then reset over an in-flight c1 read.
        nxt();
        drv(1, 1, 8'h40, 8'h01, 1, 1, 8'h41, 8'h02);
        @(negedge clock);
        chk("pre_c0_ready", bus_if.c0_ready, 1);
        nxt();
        drv(0, 0, 8'h00, 8'h00, 1, 1, 8'h41, 8'h02);
        nxt();
        drv(0, 0, 8'h00, 8'h00, 1, 0, 8'h41, 8'h00);
        @(negedge clock);
        chk("pre_c1_rd_ready", bus_if.c1_ready, 1);
        nxt();
        resetn = 1'b0;
        idle();
        @(negedge clock);
        chk("rst_drop_c1_rvalid", bus_if.c1_rvalid, 0);
        nxt();
        nxt();
        resetn = 1'b1;
        drv(1, 1, 8'h50, 8'h0A, 1, 1, 8'h51, 8'h0B);
        @(negedge clock);
        chk("post_c0_ready", bus_if.c0_ready, 1);
        chk("post_c1_ready", bus_if.c1_ready, 0);
        nxt();
        drv(0, 0, 8'h00, 8'h00, 1, 1, 8'h51, 8'h0B);
        @(negedge clock);
        chk("post_c1_ready2", bus_if.c1_ready, 1);
        nxt();
        drv(0, 0, 8'h00, 8'h00, 1, 0, 8'h41, 8'h00);
        nxt();
        idle();
        @(negedge clock);
        chk("post_c1_rdata", bus_if.c1_rdata, 8'h02);
        nxt();
        nxt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter DWIDTH, default 8, data width of the shared simple-dual-port BRAM.
REQ-002 Parameter AWIDTH, default 8, address width of the shared BRAM.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 c0_valid / c1_valid  input  1  client request present.
REQ-006 c0_we / c1_we  input  1  request type: 1 = write, 0 = read.
REQ-007 c0_addr / c1_addr  input  AWIDTH  request address.
REQ-008 c0_wdata / c1_wdata  input  DWIDTH  write data, ignored for reads.
REQ-009 c0_ready / c1_ready  output  1  request accepted this cycle (valid & ready = grant).
REQ-010 c0_rvalid / c1_rvalid  output  1  read data returned this cycle.
REQ-011 c0_rdata / c1_rdata  output  DWIDTH  read data, meaningful only with rvalid.
REQ-012 mem_we  output  1  BRAM write enable.
REQ-013 mem_wr_addr / mem_din  output  AWIDTH / DWIDTH  BRAM write port.
REQ-014 mem_rd_addr  output  AWIDTH  BRAM read address.
REQ-015 mem_dout  input  DWIDTH  BRAM registered read data, valid one cycle after mem_rd_addr.

Function
REQ-016 The write port and read port SHALL be arbitrated independently; up to one write and one read are granted per cycle.
REQ-017 One client writing and the other reading in the same cycle SHALL both be granted.
REQ-018 Both clients requesting the same port SHALL be resolved by a 1-bit round-robin pointer per port; the pointed-to client wins.
REQ-019 After a contended grant, that port's pointer SHALL move to the losing client; uncontended grants SHALL leave it unchanged.
REQ-020 A single requester on an idle port SHALL be granted in the same cycle (ready combinational from valid, zero wait).
REQ-021 ready SHALL depend only on valid/we of both clients and pointer state, never on ready; clients hold valid and payload until granted.
REQ-022 mem_we SHALL equal "write granted"; mem_wr_addr/mem_din SHALL carry the winner's addr/wdata, else 0.
REQ-023 mem_rd_addr SHALL carry the granted reader's addr, else 0.
REQ-024 A read granted in cycle N SHALL produce rvalid=1 for that client only in cycle N+1, with rdata = mem_dout.
REQ-025 A read and write to the same address in the same cycle SHALL return pre-write data (BRAM read-before-write).
REQ-026 A read granted in cycle N+1 after a write to that address in cycle N SHALL return the new data.
REQ-027 Writes SHALL produce no response; rdata of the non-responding client SHALL be 0.
REQ-028 Sustained contention SHALL alternate grants 0,1,0,1…; no client waits more than one cycle per port.

Reset
REQ-029 While resetn=0: both pointers = client 0, all ready/rvalid = 0, mem_we = 0, all address/data outputs = 0.
REQ-030 A read granted in the cycle before resetn falls SHALL produce no rvalid; the response tracker clears.
REQ-031 The first cycle after resetn rises SHALL arbitrate normally, with client 0 winning any contention.

Structure
REQ-032 Package bram_arb_pkg SHALL hold DWIDTH/AWIDTH defaults, client-index typedef (1 bit), and op enum OP_READ/OP_WRITE.
REQ-033 One sub-module bram_arb_pick (two-requester round-robin picker with pointer register) SHALL be instantiated once per port.
REQ-034 The BRAM itself SHALL be external; state is limited to two pointers plus a 2-bit response tracker (valid, client id).

Verification
REQ-035 Reset, then c0 write addr 0x10 data 0xA5 -> mem_we=1, mem_wr_addr=0x10, c0_ready=1 same cycle; then c0 read 0x10 -> c0_rvalid next cycle, c0_rdata=0xA5.
REQ-036 c0 and c1 both write, held 4 cycles -> grants c0,c1,c0,c1; ready never 1 for both in one cycle.
REQ-037 c0 write 0x20=0x3C while c1 reads 0x20 same cycle -> both ready; c1_rdata = old value; c1 re-read next cycle -> 0x3C.
REQ-038 Both read 0x01/0x02 continuously -> rvalid alternates c0/c1, each rdata matches its own address; other client's rvalid=0.
REQ-039 Grant c1 read, assert resetn=0 next cycle -> c1_rvalid stays 0; after release, contention grants c0 first.
